// File: rtl/ifu_pkg.sv
// ----------------------------------------------------------------------------
// ifu_pkg
// Shared constants and types for the instruction fetch unit.
//   XLEN             : data/address word width (32)
//   DEFAULT_RESET_PC : byte address fetched first after reset when the
//                      instantiating module does not override it
//   fetch_entry_t    : one fetch-queue entry, {fetch byte address, instruction}
// ----------------------------------------------------------------------------
package ifu_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage : ifu_pkg

// File: rtl/ifu_fifo.sv
// ----------------------------------------------------------------------------
// ifu_fifo
// Small circular fetch queue holding fetch_entry_t records.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : drop every entry (takes priority over push and pop)
//   push       : write push_data at the tail (ignored when full without a pop)
//   pop        : retire the head entry (ignored when empty)
//   push_data  : entry to enqueue
//   head       : entry currently at the head of the queue
//   full       : count == DEPTH
//   empty      : count == 0
// DEPTH must be a power of two so the pointers wrap by plain overflow.
// ----------------------------------------------------------------------------
module ifu_fifo
   import ifu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  fetch_entry_t push_data,
   output fetch_entry_t head,
   output logic         full,
   output logic         empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic             do_push;
   logic             do_pop;

   // A push into a full queue is only legal when the head leaves in the same
   // cycle; flush overrides both so a redirect never keeps stale entries.
   assign do_pop  = pop && !empty && !flush;
   assign do_push = push && (!full || do_pop) && !flush;

   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // Storage needs no reset: nothing is visible until count says so.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; the reset is asynchronous so entries
   // are discarded the moment rst_n falls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule : ifu_fifo

// File: rtl/instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// instruction_fetch_unit
// Fetches one word per cycle from a combinational instruction memory into a
// small queue that feeds decode with a valid/ready handshake.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   imem_addr      : word index into instruction memory ({2'b00, pc[31:2]})
//   imem_instr     : instruction returned by memory in the same cycle
//   branch_taken   : redirect request from execute (flushes the queue)
//   branch_addr    : redirect byte address, bits [1:0] ignored
//   out_valid      : queue head is valid
//   out_ready      : decode accepts the head this cycle
//   out_instr      : head instruction (0 when the queue is empty)
//   out_pc         : head fetch address + 4 (0 when the queue is empty)
//   stall_cycles   : only with IFU_PERF_CNT_EN defined; saturating count of
//                    cycles with out_valid && !out_ready
// Parameters:
//   RESET_PC       : first fetch byte address after reset
//   FIFO_DEPTH     : queue entries, power of two, at least 2
// Optional feature macro: IFU_PERF_CNT_EN
// ----------------------------------------------------------------------------
module instruction_fetch_unit
   import ifu_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int              FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_instr,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_addr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_instr,
`ifdef IFU_PERF_CNT_EN
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] stall_cycles
`else
   output logic [XLEN-1:0] out_pc
`endif
);

   logic [XLEN-1:0] pc;
   logic            fifo_full;
   logic            fifo_empty;
   logic            push;
   logic            pop;
   fetch_entry_t    head;
   fetch_entry_t    fetched;

   // A redirect suppresses both handshakes for the cycle; otherwise the head
   // leaves whenever decode takes it, and a fetch happens whenever there is
   // (or is about to be) room for it.
   assign pop  = !branch_taken && !fifo_empty && out_ready;
   assign push = !branch_taken && (!fifo_full || pop);

   assign fetched.pc    = pc;
   assign fetched.instr = imem_instr;

   assign imem_addr = {2'b00, pc[XLEN-1:2]};

   // Outputs read as zero while the queue is empty so reset and flush leave
   // a clean, deterministic interface toward decode.
   assign out_valid = !fifo_empty;
   assign out_instr = fifo_empty ? '0 : head.instr;
   assign out_pc    = fifo_empty ? '0 : head.pc + XLEN'(4);

   // Program counter: redirect wins, otherwise advance on every fetch and
   // hold while the queue is full and stalled. Wraps naturally at 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (branch_taken) begin
         pc <= {branch_addr[XLEN-1:2], 2'b00};
      end else if (push) begin
         pc <= pc + XLEN'(4);
      end
   end

   ifu_fifo #(
      .DEPTH     (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (branch_taken),
      .push      (push),
      .pop       (pop),
      .push_data (fetched),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

`ifdef IFU_PERF_CNT_EN
   // Back-pressure counter: counts cycles where decode refuses a valid head,
   // saturating instead of wrapping so long runs never read as small.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if (out_valid && !out_ready && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + XLEN'(1);
      end
   end
`endif

endmodule : instruction_fetch_unit

// File: tb/tb_instruction_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Directed, self-checking bench for instruction_fetch_unit. A queue-based
// model predicts every entry the DUT should deliver; each cycle the head is
// compared against the model's front entry. A second instance checks pc
// wrap-around from RESET_PC = 32'hFFFF_FFF8. Define IFU_PERF_CNT_EN to also
// check stall_cycles.
// ----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

   localparam int DEPTH = 2;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        branch_taken;
   logic [31:0] branch_addr;
   logic        out_ready;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;

   logic [31:0] imem_addr2;
   logic [31:0] imem_instr2;
   logic        out_valid2;
   logic [31:0] out_instr2;
   logic [31:0] out_pc2;

   int          passCount;
   int          failCount;
   int          totalCount;

   exp_t        expQ[$];
   logic [31:0] modelPc;
   logic [31:0] modelStall;

`ifdef IFU_PERF_CNT_EN
   logic [31:0] stall_cycles;
   logic [31:0] stall_cycles2;
`endif

   // Combinational instruction memory: word i holds 32'hE000_0000 + i.
   assign imem_instr  = 32'hE000_0000 + imem_addr;
   assign imem_instr2 = 32'hE000_0000 + imem_addr2;

   instruction_fetch_unit #(
      .RESET_PC     (32'h0000_0000),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem_addr    (imem_addr),
      .imem_instr   (imem_instr),
      .branch_taken (branch_taken),
      .branch_addr  (branch_addr),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_instr    (out_instr),
`ifdef IFU_PERF_CNT_EN
      .out_pc       (out_pc),
      .stall_cycles (stall_cycles)
`else
      .out_pc       (out_pc)
`endif
   );

   instruction_fetch_unit #(
      .RESET_PC     (32'hFFFF_FFF8),
      .FIFO_DEPTH   (DEPTH)
   ) dut_wrap (
      .clk          (clk),
      .rst_n        (rst_n),
      .imem_addr    (imem_addr2),
      .imem_instr   (imem_instr2),
      .branch_taken (1'b0),
      .branch_addr  (32'h0000_0000),
      .out_valid    (out_valid2),
      .out_ready    (1'b1),
      .out_instr    (out_instr2),
`ifdef IFU_PERF_CNT_EN
      .out_pc       (out_pc2),
      .stall_cycles (stall_cycles2)
`else
      .out_pc       (out_pc2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts, asserts, reports.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      totalCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      expQ.delete();
      modelPc    = 32'h0000_0000;
      modelStall = 32'h0000_0000;
   endtask

   // Called at a falling edge: drives this cycle's inputs, compares the DUT
   // against the model's head, advances the model by one rising edge, and
   // returns at the next falling edge.
   task automatic applyStimulus(input logic rdy, input logic br, input logic [31:0] baddr);
      logic  doPop;
      logic  doPush;
      exp_t  e;
      out_ready    = rdy;
      branch_taken = br;
      branch_addr  = baddr;
      #1;
      checkOutput("imem_addr", imem_addr, {2'b00, modelPc[31:2]});
      checkOutput("out_valid", {31'b0, out_valid}, {31'b0, expQ.size() != 0});
      if (expQ.size() != 0) begin
         checkOutput("out_instr", out_instr, expQ[0].instr);
         checkOutput("out_pc", out_pc, expQ[0].pc + 32'd4);
      end
`ifdef IFU_PERF_CNT_EN
      checkOutput("stall_cycles", stall_cycles, modelStall);
`endif
      if (expQ.size() != 0 && !rdy && modelStall != 32'hFFFF_FFFF) modelStall++;
      if (br) begin
         expQ.delete();
         modelPc = {baddr[31:2], 2'b00};
      end else begin
         doPop  = (expQ.size() != 0) && rdy;
         doPush = (expQ.size() < DEPTH) || doPop;
         if (doPop) void'(expQ.pop_front());
         if (doPush) begin
            e.pc    = modelPc;
            e.instr = 32'hE000_0000 + {2'b00, modelPc[31:2]};
            expQ.push_back(e);
            modelPc = modelPc + 32'd4;
         end
      end
      @(negedge clk);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
      checkOutput({tag, "_instr"}, out_instr, 32'd0);
      checkOutput({tag, "_pc"}, out_pc, 32'd0);
      checkOutput({tag, "_imem_addr"}, imem_addr, 32'd0);
`ifdef IFU_PERF_CNT_EN
      checkOutput({tag, "_stall"}, stall_cycles, 32'd0);
`endif
   endtask

   initial begin
      logic [31:0] wrapPc [3];
      wrapPc[0] = 32'hFFFF_FFFC;
      wrapPc[1] = 32'h0000_0000;
      wrapPc[2] = 32'h0000_0004;
      passCount    = 0;
      failCount    = 0;
      totalCount   = 0;
      rst_n        = 1'b0;
      out_ready    = 1'b0;
      branch_taken = 1'b0;
      branch_addr  = 32'h0;
      modelReset();

      // Reset state, including the wrap instance's first address.
      repeat (2) @(negedge clk);
      checkResetState("reset");
      checkOutput("wrap_reset_imem_addr", imem_addr2, 32'h3FFF_FFFE);
      checkOutput("wrap_reset_valid", {31'b0, out_valid2}, 32'd0);

      // Streaming after reset release with decode always ready; the wrap
      // instance runs alongside.
      $display("[TB] streaming from reset");
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i == 0) checkOutput("wrap_empty", {31'b0, out_valid2}, 32'd0);
         if (i >= 1 && i <= 3) begin
            checkOutput("wrap_out_pc", out_pc2, wrapPc[i-1]);
            checkOutput("wrap_head_pc", out_pc2 - 32'd4, wrapPc[i-1] - 32'd4);
         end
         if (i == 1) checkOutput("stream_first", out_instr, 32'hE000_0000);
         if (i == 2) checkOutput("stream_second", out_instr, 32'hE000_0001);
         applyStimulus(1'b1, 1'b0, 32'h0);
      end

      // Back-pressure from a fresh reset: queue fills, pc freezes.
      $display("[TB] back-pressure hold");
      rst_n = 1'b0;
      #1;
      modelReset();
      checkResetState("midrun_reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i >= 3) begin
            checkOutput("hold_imem_addr", imem_addr, 32'd2);
            checkOutput("hold_head", out_instr, 32'hE000_0000);
         end
         applyStimulus(1'b0, 1'b0, 32'h0);
      end
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'h0);

      // Branch while full and stalled.
      $display("[TB] branch on full queue");
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'h0000_0014);
      checkOutput("br_bubble", {31'b0, out_valid}, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("br_target_instr", out_instr, 32'hE000_0005);
      checkOutput("br_target_pc", out_pc, 32'h0000_0018);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0);

      // Branch together with out_ready on a full queue; low address bits
      // are ignored.
      $display("[TB] branch with ready on full queue");
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b1, 32'h0000_0043);
      checkOutput("br_rdy_bubble", {31'b0, out_valid}, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("br_rdy_instr", out_instr, 32'hE000_0010);
      checkOutput("br_rdy_pc", out_pc, 32'h0000_0044);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0);

      // Seven back-pressured valid cycles, then an asynchronous reset.
      $display("[TB] stall counting and async reset");
      rst_n = 1'b0;
      #1;
      modelReset();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 32'h0);
`ifdef IFU_PERF_CNT_EN
      checkOutput("stall_seven", stall_cycles, 32'd7);
`endif
      rst_n = 1'b0;
      #1;
      modelReset();
      checkResetState("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'h0);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule : tb_instruction_fetch_unit
